// File: rtl/fan_ctrl_pwm.sv
// Fan controller: debounced-by-edge speed buttons, soft ramping between
// speed levels, PWM fan drive and an optional auto-off timer.
module fan_ctrl_pwm #(
    parameter int unsigned NUM_LEVELS      = 4,
    parameter int unsigned PWM_PERIOD      = 100,
    parameter int unsigned RAMP_CYCLES     = 1000,
    parameter int unsigned AUTO_OFF_CYCLES = 1000000,
    localparam int unsigned LVL_W          = $clog2(NUM_LEVELS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NUM_LEVELS:0]   i_button,
    input  logic                  i_timer,
    output logic [LVL_W-1:0]      o_fanState,
    output logic [LVL_W-1:0]      o_target,
    output logic                  o_pwm,
    output logic                  o_busy,
    output logic                  o_timer_armed
);

    localparam int unsigned PWM_W  = $clog2(PWM_PERIOD);
    localparam int unsigned RAMP_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam int unsigned TMR_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RAMP_UP,
        ST_RAMP_DOWN
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_LEVELS:0] btn_q;
    logic                tmr_q;
    logic [LVL_W-1:0]    fan_q, fan_d;
    logic [LVL_W-1:0]    target_q, target_d;
    logic                armed_q, armed_d;
    logic                busy_q, busy_d;
    logic                pwm_q, pwm_d;
    logic [TMR_W-1:0]    tmr_cnt_q, tmr_cnt_d;
    logic [RAMP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
    logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;

    logic [NUM_LEVELS:0] btn_evt;
    logic                tmr_evt;
    logic                evt_any;
    logic                lvl_evt_any;
    logic [LVL_W-1:0]    evt_lvl;
    logic                expire;

    // Next-state: button events, auto-off timer, ramp stepping, PWM and FSM
    always_comb begin
        btn_evt     = i_button & ~btn_q;
        tmr_evt     = i_timer & ~tmr_q;
        evt_any     = 1'b0;
        evt_lvl     = '0;
        lvl_evt_any = |btn_evt[NUM_LEVELS:1];
        expire      = armed_q && (target_q != '0) && (tmr_cnt_q <= TMR_W'(1));
        target_d    = target_q;
        armed_d     = armed_q;
        tmr_cnt_d   = tmr_cnt_q;
        fan_d       = fan_q;
        ramp_cnt_d  = '0;
        pwm_cnt_d   = '0;
        pwm_d       = 1'b0;
        state_d     = ST_IDLE;
        busy_d      = 1'b0;

        // Scan from the top so the lowest pressed index is the one kept
        for (int k = int'(NUM_LEVELS); k >= 0; k--) begin
            if (btn_evt[k]) begin
                evt_any = 1'b1;
                evt_lvl = LVL_W'(k);
            end
        end

        if (evt_any && (evt_lvl != target_q)) begin
            target_d = evt_lvl;
        end

        if (tmr_evt) begin
            armed_d   = !armed_q;
            tmr_cnt_d = armed_q ? '0 : TMR_W'(AUTO_OFF_CYCLES);
        end else if (armed_q) begin
            if (lvl_evt_any) begin
                tmr_cnt_d = TMR_W'(AUTO_OFF_CYCLES);
            end else if (target_q != '0) begin
                tmr_cnt_d = tmr_cnt_q - TMR_W'(1);
            end
        end

        // Timeout overrides any coincident button or timer event
        if (expire) begin
            target_d  = '0;
            armed_d   = 1'b0;
            tmr_cnt_d = '0;
        end

        if ((state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN)) begin
            if (ramp_cnt_q == RAMP_W'(RAMP_CYCLES - 1)) begin
                ramp_cnt_d = '0;
                fan_d      = (state_q == ST_RAMP_UP) ? fan_q + LVL_W'(1)
                                                     : fan_q - LVL_W'(1);
            end else begin
                ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
            end
        end

        if (pwm_cnt_q != PWM_W'(PWM_PERIOD - 1)) begin
            pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        end
        pwm_d = (32'(pwm_cnt_q) * 32'(NUM_LEVELS)) < (32'(fan_q) * 32'(PWM_PERIOD));

        if (fan_d == target_d) begin
            state_d = (fan_d == '0) ? ST_IDLE : ST_HOLD;
        end else if (fan_d < target_d) begin
            state_d = ST_RAMP_UP;
        end else begin
            state_d = ST_RAMP_DOWN;
        end
        busy_d = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
    end

    // State register with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            btn_q      <= i_button;
            tmr_q      <= i_timer;
            fan_q      <= '0;
            target_q   <= '0;
            armed_q    <= 1'b0;
            busy_q     <= 1'b0;
            pwm_q      <= 1'b0;
            tmr_cnt_q  <= '0;
            ramp_cnt_q <= '0;
            pwm_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            btn_q      <= i_button;
            tmr_q      <= i_timer;
            fan_q      <= fan_d;
            target_q   <= target_d;
            armed_q    <= armed_d;
            busy_q     <= busy_d;
            pwm_q      <= pwm_d;
            tmr_cnt_q  <= tmr_cnt_d;
            ramp_cnt_q <= ramp_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
        end
    end

    assign o_fanState    = fan_q;
    assign o_target      = target_q;
    assign o_pwm         = pwm_q;
    assign o_busy        = busy_q;
    assign o_timer_armed = armed_q;

endmodule

// File: tb/tb_fan_ctrl_pwm.sv
// Scoreboard bench for fan_ctrl_pwm: expected output-tuple changes (with the
// cycle they must occur on) and PWM duty windows are queued by the stimulus
// and checked by independent monitors.
module tb_fan_ctrl_pwm;

    localparam int unsigned NL    = 4;
    localparam int unsigned LVL_W = 3;

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } exp_t;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic [NL:0]      i_button;
    logic             i_timer;
    logic [LVL_W-1:0] o_fanState;
    logic [LVL_W-1:0] o_target;
    logic             o_pwm;
    logic             o_busy;
    logic             o_timer_armed;

    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    logic mon_en    = 1'b0;
    logic [7:0] last_val = 8'h00;
    exp_t exp_q[$];
    int   pwm_q[$];
    logic pwm_busy  = 1'b0;
    int   pwm_exp   = 0;
    int   pwm_hi    = 0;
    int   pwm_n     = 0;

    fan_ctrl_pwm #(
        .NUM_LEVELS     (NL),
        .PWM_PERIOD     (8),
        .RAMP_CYCLES    (4),
        .AUTO_OFF_CYCLES(20)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_button     (i_button),
        .i_timer      (i_timer),
        .o_fanState   (o_fanState),
        .o_target     (o_target),
        .o_pwm        (o_pwm),
        .o_busy       (o_busy),
        .o_timer_armed(o_timer_armed)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_at(input int fan, input int tgt, input int busy,
                             input int armed, input int at_cyc);
        exp_t e;
        e.val = {3'(fan), 3'(tgt), 1'(busy), 1'(armed)};
        e.cyc = at_cyc;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic pulse_btn(input logic [NL:0] bits);
        i_button = bits;
        @(negedge i_clk);
        i_button = '0;
    endtask

    task automatic pulse_tmr();
        i_timer = 1'b1;
        @(negedge i_clk);
        i_timer = 1'b0;
    endtask

    // Output monitor: every change of {fan,target,busy,armed} consumes one expectation
    always @(negedge i_clk) begin
        logic [7:0] cur;
        exp_t       e;
        if (mon_en) begin
            cur = {o_fanState, o_target, o_busy, o_timer_armed};
            if (cur != last_val) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got fan=%0d tgt=%0d busy=%0d armed=%0d at cycle %0d, none expected",
                             cur[7:5], cur[4:2], cur[1], cur[0], cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ((e.val != cur) || (e.cyc != cyc)) begin
                        n_fail++;
                        $display("FAIL state_change: got fan=%0d tgt=%0d busy=%0d armed=%0d @%0d expected fan=%0d tgt=%0d busy=%0d armed=%0d @%0d",
                                 cur[7:5], cur[4:2], cur[1], cur[0], cyc,
                                 e.val[7:5], e.val[4:2], e.val[1], e.val[0], e.cyc);
                    end
                end
                last_val = cur;
            end
        end
    end

    // PWM monitor: counts high cycles over one 8-cycle period per request
    always @(negedge i_clk) begin
        if (pwm_busy) begin
            if (o_pwm) pwm_hi++;
            pwm_n++;
            if (pwm_n == 8) begin
                n_checks++;
                if (pwm_hi != pwm_exp) begin
                    n_fail++;
                    $display("FAIL pwm_duty: got %0d high of 8 expected %0d (cycle %0d)", pwm_hi, pwm_exp, cyc);
                end
                pwm_busy = 1'b0;
            end
        end else if (pwm_q.size() > 0) begin
            pwm_exp  = pwm_q.pop_front();
            pwm_hi   = 0;
            pwm_n    = 0;
            pwm_busy = 1'b1;
        end
    end

    initial begin
        int c;
        int c2;
        i_reset  = 1'b0;
        i_button = 5'b01000;
        i_timer  = 1'b0;

        // Reset with a button held through it: no event afterwards
        wait_cyc(3);
        mon_en  = 1'b1;
        i_reset = 1'b1;
        wait_cyc(3);
        chk("rst_fanState", int'(o_fanState), 0);
        chk("rst_target", int'(o_target), 0);
        chk("rst_pwm", int'(o_pwm), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_armed", int'(o_timer_armed), 0);
        i_button = '0;
        wait_cyc(2);

        // Ramp 0 -> 3, one level every 4 cycles
        c = cyc;
        expect_at(0, 3, 1, 0, c + 1);
        expect_at(1, 3, 1, 0, c + 5);
        expect_at(2, 3, 1, 0, c + 9);
        expect_at(3, 3, 0, 0, c + 13);
        pulse_btn(5'b01000);
        wait_cyc(20);

        // Held bit2 gives one event; bits 1 and 4 together -> level 1 wins
        c = cyc;
        expect_at(3, 2, 1, 0, c + 1);
        expect_at(2, 2, 0, 0, c + 5);
        i_button = 5'b00100;
        wait_cyc(50);
        c2 = cyc;
        expect_at(2, 1, 1, 0, c2 + 1);
        expect_at(1, 1, 0, 0, c2 + 5);
        i_button = 5'b10110;
        wait_cyc(3);
        i_button = '0;
        wait_cyc(10);
        pwm_q.push_back(2);
        wait_cyc(12);

        // Level 2: half duty
        c = cyc;
        expect_at(1, 2, 1, 0, c + 1);
        expect_at(2, 2, 0, 0, c + 5);
        pulse_btn(5'b00100);
        wait_cyc(10);
        pwm_q.push_back(4);
        wait_cyc(12);

        // Auto-off after 20 cycles, then soft ramp down
        c = cyc;
        expect_at(2, 2, 0, 1, c + 1);
        expect_at(2, 0, 1, 0, c + 21);
        expect_at(1, 0, 1, 0, c + 25);
        expect_at(0, 0, 0, 0, c + 29);
        pulse_tmr();
        wait_cyc(35);
        pwm_q.push_back(0);
        wait_cyc(12);

        // Direction reversal mid-ramp
        c = cyc;
        expect_at(0, 4, 1, 0, c + 1);
        expect_at(1, 4, 1, 0, c + 5);
        expect_at(2, 4, 1, 0, c + 9);
        expect_at(2, 1, 1, 0, c + 10);
        expect_at(1, 1, 0, 0, c + 13);
        pulse_btn(5'b10000);
        wait_cyc(8);
        pulse_btn(5'b00010);
        wait_cyc(10);

        // Ramp to full speed: constant high PWM
        c = cyc;
        expect_at(1, 4, 1, 0, c + 1);
        expect_at(2, 4, 1, 0, c + 5);
        expect_at(3, 4, 1, 0, c + 9);
        expect_at(4, 4, 0, 0, c + 13);
        pulse_btn(5'b10000);
        wait_cyc(20);
        pwm_q.push_back(8);
        wait_cyc(12);

        // Same-level event reloads the armed timer without changing target
        c = cyc;
        expect_at(4, 4, 0, 1, c + 1);
        expect_at(4, 0, 1, 0, c + 32);
        expect_at(3, 0, 1, 0, c + 36);
        expect_at(2, 0, 1, 0, c + 40);
        expect_at(1, 0, 1, 0, c + 44);
        expect_at(0, 0, 0, 0, c + 48);
        pulse_tmr();
        wait_cyc(10);
        pulse_btn(5'b10000);
        wait_cyc(45);

        // Timer button toggles armed on and off
        c = cyc;
        expect_at(0, 0, 0, 1, c + 1);
        expect_at(0, 0, 0, 0, c + 3);
        pulse_tmr();
        wait_cyc(1);
        pulse_tmr();
        wait_cyc(5);

        // Reset mid-ramp aborts; ramp timing afterwards starts clean
        c = cyc;
        expect_at(0, 3, 1, 0, c + 1);
        expect_at(1, 3, 1, 0, c + 5);
        expect_at(0, 0, 0, 0, c + 7);
        pulse_btn(5'b01000);
        wait_cyc(5);
        i_reset = 1'b0;
        wait_cyc(2);
        i_reset = 1'b1;
        wait_cyc(2);
        c = cyc;
        expect_at(0, 1, 1, 0, c + 1);
        expect_at(1, 1, 0, 0, c + 5);
        pulse_btn(5'b00010);
        wait_cyc(10);

        chk("exp_queue_drained", exp_q.size(), 0);
        chk("pwm_queue_drained", pwm_q.size() + int'(pwm_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fan_ctrl_pwm.md
FAN_CTRL_PWM -- requirements
Module: fan_ctrl_pwm

Interface
REQ-001 Parameter NUM_LEVELS, default 4: number of non-off speed levels, legal range 1..15.
REQ-002 Parameter PWM_PERIOD, default 100: PWM period in i_clk cycles, legal range 2..65535.
REQ-003 Parameter RAMP_CYCLES, default 1000: cycles per one-level ramp step, legal range 1..2^20.
REQ-004 Parameter AUTO_OFF_CYCLES, default 1000000: auto-off timeout in cycles, legal range 1..2^32-1.
REQ-005 Derived LVL_W = clog2(NUM_LEVELS+1).
REQ-006 i_clk  input  1  single clock; all logic on rising edge.
REQ-007 i_reset  input  1  synchronous, active-low reset.
REQ-008 i_button  input  NUM_LEVELS+1  bit0 = off, bit k = speed level k; level-sensitive raw buttons.
REQ-009 i_timer  input  1  auto-off arm/disarm button.
REQ-010 o_fanState  output  LVL_W  current (ramped) speed level, 0 = off.
REQ-011 o_target  output  LVL_W  requested speed level.
REQ-012 o_pwm  output  1  fan drive PWM.
REQ-013 o_busy  output  1  high while o_fanState != o_target.
REQ-014 o_timer_armed  output  1  auto-off timer armed.

Function
REQ-015 Button events: rising-edge detection on every i_button bit and i_timer using a registered copy of the previous sample; a held button produces exactly one event.
REQ-016 Event latency: input sampled high at edge k and low at edge k-1 -> o_target (or o_timer_armed) updated at edge k.
REQ-017 Multiple i_button events in one cycle: lowest index wins (off has highest priority).
REQ-018 Event for level equal to current o_target: no change; still reloads auto-off timer if armed.
REQ-019 Ramp FSM states: IDLE (fanState=target=0), HOLD (fanState=target!=0), RAMP_UP (fanState<target), RAMP_DOWN (fanState>target); o_busy high in RAMP_UP/RAMP_DOWN only.
REQ-020 Ramp step counter counts 0..RAMP_CYCLES-1 while busy; on wrap o_fanState moves one level toward o_target; counter held at 0 when not busy.
REQ-021 First step lands exactly RAMP_CYCLES cycles after o_target changes from a non-busy state.
REQ-022 Target change mid-ramp: step counter not cleared; direction re-evaluated each step; reversal allowed.
REQ-023 Off event ramps down (soft stop), no immediate jump to 0.
REQ-024 PWM counter free-runs 0..PWM_PERIOD-1 and wraps.
REQ-025 o_pwm = 1 iff cnt*NUM_LEVELS < o_fanState*PWM_PERIOD, computed without division, registered; level 0 -> constant 0, level NUM_LEVELS -> constant 1.
REQ-026 i_timer event toggles o_timer_armed; arming loads down-counter with AUTO_OFF_CYCLES.
REQ-027 While armed and o_target != 0: counter decrements per cycle; any level event (bit k>=1) reloads it.
REQ-028 While armed and o_target == 0: counter holds its value.
REQ-029 Counter reaching 0 -> o_target set to 0 and o_timer_armed cleared in the same edge; the ramp-down follows.
REQ-030 Expiry coincident with a button event: expiry wins, event discarded.
REQ-031 Expiry coincident with an i_timer event: timer ends disarmed.

Reset
REQ-032 i_reset low at a rising edge: o_fanState=0, o_target=0, o_pwm=0, o_busy=0, o_timer_armed=0, all counters 0, edge registers loaded with current inputs (buttons held through reset yield no event).
REQ-033 Reset mid-ramp or mid-timeout aborts immediately; no residual state.

Verification (NUM_LEVELS=4, PWM_PERIOD=8, RAMP_CYCLES=4, AUTO_OFF_CYCLES=20)
REQ-034 Reset low 3 cycles with i_button=5'b01000 held, then release reset -> all outputs 0, no event after reset.
REQ-035 From IDLE pulse bit3 one cycle -> o_target=3 next edge; o_fanState=1,2,3 at +4,+8,+12 cycles; o_busy low at +12.
REQ-036 Bit2 held 50 cycles, then bits 1 and 4 rising in the same cycle -> exactly one target change to 2, then o_target=1.
REQ-037 At HOLD level 2 -> o_pwm high 4 of every 8 cycles; level 4 -> constant high; level 0 -> constant low.
REQ-038 At level 2 pulse i_timer -> o_timer_armed=1; 20 cycles later o_target=0, o_timer_armed=0, o_fanState reaches 0 after 8 more cycles.
REQ-039 Ramping 0->4, at fanState=2 pulse bit1 -> direction reverses, o_fanState=1 at next step, o_busy drops.
